water_fill_arbiter: RTL and testbench
=====================================

# water_fill_arbiter

Round-robin arbiter that shares one mains water inlet valve among `N` washing-machine controllers in a multi-drum installation. Each controller raises a fill request when its FSM enters a fill phase. The arbiter opens the valve for one requester at a time and closes it on level-full, on request withdrawal, or on a fill timeout. It enforces a valve-settle gap between consecutive grants and flags requesters whose fill timed out.

## Interface
Parameters:
- `N`, 4: number of requesting controllers (2..8).
- `FILL_MAX`, 200: maximum cycles a single grant may stay open (1..1023).
- `GAP`, 2: valve-settle cycles after each close (1..15).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  fill request per controller; level, held until served or withdrawn.
- `full`  in  N  water-level-full sensor per controller.
- `grant`  out  N  one-hot fill grant; all-zero when the valve is closed.
- `valve_open`  out  1  drives the shared inlet valve; equals `|grant`.
- `active_id`  out  3  index of the current or last granted requester.
- `timeout_err`  out  N  sticky per-requester fill-timeout flag.
- `busy`  out  1  high in FILL and CLOSE states.

## Operation
- States: IDLE, FILL, CLOSE. All outputs are registered.
- **Reset:** state=IDLE, `grant`=0, `valve_open`=0, `active_id`=0, `timeout_err`=0, `busy`=0, round-robin pointer `ptr`=0, counters=0.
  - Reset asserted mid-FILL closes the valve asynchronously, with no settle gap.
- **Eligibility:** requester `i` is eligible when `req[i]=1` and `timeout_err[i]=0`.
- **IDLE:**
  - If any requester is eligible, select the first eligible index searching `ptr, ptr+1, ..., N-1, 0, ...`.
  - On that edge: `grant[i]=1`, `valve_open=1`, `active_id=i`, `busy=1`, fill counter=1, go to FILL.
  - If no requester is eligible, stay in IDLE.
- **FILL (granted `i`):** evaluate each edge in this priority order:
  - (a) `full[i]=1`: normal close.
  - (b) `req[i]=0`: abort close, no flag.
  - (c) fill counter == `FILL_MAX`: close and set `timeout_err[i]=1`.
  - (d) otherwise: increment the counter.
  - On any close: `grant=0`, `valve_open=0`, `ptr=(i+1) mod N`, settle counter=`GAP`, go to CLOSE.
- **CLOSE:** decrement the settle counter each edge; at 1, go to IDLE (`busy=0`). Requests are ignored during CLOSE.
- **timeout_err[j]:** clears on any edge where `req[j]=0`. A flagged requester is skipped until it withdraws and re-requests.
- Counter widths: fill counter 10 bits; settle counter 4 bits. No wrap-around is possible given the parameter ranges.
- `full` on a non-granted requester is ignored.
- Changes to `req` from other requesters during FILL do not affect the current grant.

## Timing
- **Request latency:** with the arbiter idle, a request sampled at edge t gives `grant` high after edge t (one cycle).
- **Grant duration:** if `full[i]` is first sampled high on the k-th cycle of the grant, `grant` is high for exactly k cycles.
- **Timeout:** if `full` never rises, `grant` is high for exactly `FILL_MAX` cycles. `timeout_err[i]` rises on the same edge that `grant` falls.
- **Full at the limit:** `full` sampled high in the `FILL_MAX`-th cycle counts as a normal close, with no error.
- **Back-to-back turnaround:** `grant` is low for `GAP` CLOSE cycles plus 1 IDLE cycle before the next grant.
  - At the defaults this is 3 cycles.
  - `valve_open` is never high for two different requesters without this gap.

## Test plan
1. `req[0]=1` from idle, `full[0]` rises on the 5th grant cycle -> `grant=0001` for 5 cycles, then 3 low cycles, `busy` high for 7 cycles, `timeout_err=0`.
2. `req=1111` held with `ptr=0`, each full after 4 cycles -> grants in order 0,1,2,3,0 with a 3-cycle gap between each; `active_id` follows the same order.
3. `req[2]=1`, `full` never -> `grant[2]` high for exactly 200 cycles, then `timeout_err[2]=1`. With `req[2]` still held there is no re-grant. `req[2]=0` for one cycle -> flag clears; re-request -> granted again.
4. `req[1]` dropped on the 10th grant cycle -> `grant` falls on that edge, `timeout_err[1]=0`, `ptr=2`.
5. `full[3]` rises exactly on the 200th grant cycle -> normal close, `timeout_err[3]=0`.
6. `rst` pulsed mid-FILL (cycle 50 of requester 1) -> `grant`/`valve_open` fall immediately. After release, `req=0011` grants requester 0 first (`ptr=0`).

Source files
------------

// File: rtl/water_fill_if.sv
// Handshake bundle between the washing-machine controllers and the shared
// inlet-valve arbiter.
interface water_fill_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] full;
  logic [N-1:0] grant;
  logic         valve_open;
  logic [2:0]   active_id;
  logic [N-1:0] timeout_err;
  logic         busy;

  modport master (
    output req, full,
    input  grant, valve_open, active_id, timeout_err, busy
  );

  modport slave (
    input  req, full,
    output grant, valve_open, active_id, timeout_err, busy
  );
endinterface

// File: rtl/water_fill_arbiter.sv
// Round-robin arbiter for one shared mains inlet valve: one fill at a time,
// closed on full, withdrawal or timeout, with a settle gap between grants.
module water_fill_arbiter #(
  parameter int N        = 4,
  parameter int FILL_MAX = 200,
  parameter int GAP      = 2
) (
  input logic        clk,
  input logic        rst,
  water_fill_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CLOSE} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [N-1:0] err_q, err_d;
  logic         valve_q, valve_d;
  logic         busy_q, busy_d;
  logic [2:0]   id_q, id_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [9:0]   fill_cnt_q, fill_cnt_d;
  logic [3:0]   settle_q, settle_d;

  logic [N-1:0] eligible;
  logic         cur_full, cur_req;
  logic         found;
  logic [2:0]   pick;

  assign eligible = bus.req & ~err_q;

  // Round-robin search starting at ptr, plus the granted requester's inputs.
  always_comb begin
    int cand;
    found    = 1'b0;
    pick     = '0;
    cur_full = 1'b0;
    cur_req  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = 3'(cand);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (id_q == 3'(i)) begin
        cur_full = bus.full[i];
        cur_req  = bus.req[i];
      end
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    valve_d    = valve_q;
    busy_d     = busy_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    fill_cnt_d = fill_cnt_q;
    settle_d   = settle_q;
    // A flag only survives while its requester keeps asking.
    err_d      = err_q & bus.req;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          for (int i = 0; i < N; i++) grant_d[i] = (pick == 3'(i));
          valve_d    = 1'b1;
          busy_d     = 1'b1;
          id_d       = pick;
          fill_cnt_d = 10'd1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (cur_full || !cur_req || fill_cnt_q == 10'(FILL_MAX)) begin
          grant_d  = '0;
          valve_d  = 1'b0;
          ptr_d    = (id_q == 3'(N - 1)) ? 3'd0 : id_q + 3'd1;
          settle_d = 4'(GAP);
          state_d  = S_CLOSE;
          if (!cur_full && cur_req) begin
            for (int i = 0; i < N; i++)
              if (id_q == 3'(i)) err_d[i] = 1'b1;
          end
        end else begin
          fill_cnt_d = fill_cnt_q + 10'd1;
        end
      end
      S_CLOSE: begin
        if (settle_q == 4'd1) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      err_q      <= '0;
      valve_q    <= 1'b0;
      busy_q     <= 1'b0;
      id_q       <= '0;
      ptr_q      <= '0;
      fill_cnt_q <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      valve_q    <= valve_d;
      busy_q     <= busy_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      fill_cnt_q <= fill_cnt_d;
      settle_q   <= settle_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.valve_open  = valve_q;
  assign bus.active_id   = id_q;
  assign bus.timeout_err = err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_water_fill_arbiter.sv
// Self-checking bench for water_fill_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural valve-sharing model.
module tb_water_fill_arbiter;
  localparam int N        = 4;
  localparam int FILL_MAX = 200;
  localparam int GAP      = 2;
  localparam int VW       = 2 * N + 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  water_fill_if #(.N(N)) bus ();

  water_fill_arbiter #(.N(N), .FILL_MAX(FILL_MAX), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who holds the valve, how long it has been open, remaining settle
  // cycles, next round-robin start and the sticky timeout flags.
  int m_owner, m_last, m_age, m_settle, m_ptr;
  bit m_err[N];

  function automatic void model_reset();
    m_owner  = -1;
    m_last   = 0;
    m_age    = 0;
    m_settle = 0;
    m_ptr    = 0;
    for (int j = 0; j < N; j++) m_err[j] = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] f);
    bit old_err[N];
    bit done;
    int j;
    old_err = m_err;
    done    = 1'b0;
    for (int i = 0; i < N; i++) if (!r[i]) m_err[i] = 1'b0;
    if (m_owner >= 0) begin
      if (f[m_owner]) done = 1'b1;
      else if (!r[m_owner]) done = 1'b1;
      else if (m_age == FILL_MAX) begin
        done = 1'b1;
        m_err[m_owner] = 1'b1;
      end else m_age++;
      if (done) begin
        m_ptr    = (m_owner + 1) % N;
        m_owner  = -1;
        m_settle = GAP;
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (m_owner < 0 && r[j] && !old_err[j]) begin
          m_owner = j;
          m_last  = j;
          m_age   = 1;
        end
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g, e;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    for (int j = 0; j < N; j++) e[j] = m_err[j];
    return {g, |g, 3'(m_last), e, (m_owner >= 0) || (m_settle > 0)};
  endfunction

  wire [VW-1:0] act_vec = {bus.grant, bus.valve_open, bus.active_id, bus.timeout_err, bus.busy};

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick(input string tag);
    logic [VW-1:0] e;
    @(posedge clk);
    model_step(bus.req, bus.full);
    #1;
    e = exp_vec();
    n_cmp++;
    if (act_vec !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t: {grant,valve,id,err,busy} got %b expected %b", tag, $time, act_vec, e);
    end
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    bus.req  = '0;
    bus.full = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic drain();
    bus.req  = '0;
    bus.full = '0;
    repeat (GAP + 4) tick("drain");
  endtask

  // Wait for grant[idx], then raise full / drop req on the given grant cycle.
  task automatic serve(input int idx, input int full_at, input int drop_at, input string tag,
                       output int glen, output int waited);
    waited = 0;
    glen   = 0;
    while (bus.grant[idx] !== 1'b1 && waited < 50) begin
      tick(tag);
      waited++;
    end
    n_cmp++;
    if (bus.grant[idx] !== 1'b1 || bus.active_id !== 3'(idx)) begin
      n_bad++;
      $display("FAIL %s_grant: grant=%b id=%0d, required grant[%0d] id=%0d",
               tag, bus.grant, bus.active_id, idx, idx);
      return;
    end
    glen = 1;
    while (glen <= FILL_MAX + 5) begin
      if (glen == full_at) bus.full[idx] = 1'b1;
      if (glen == drop_at) bus.req[idx] = 1'b0;
      tick(tag);
      if (bus.grant[idx] === 1'b1) glen++;
      else break;
    end
    bus.full[idx] = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++;
    if (act_vec !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected all zero", act_vec);
    end
  endtask

  task automatic test_single_fill();
    int glen, waited, low, busy_cnt;
    reset_dut();
    bus.req[0] = 1'b1;
    serve(0, 5, 0, "single", glen, waited);
    n_cmp++;
    if (glen != 5) begin
      n_bad++;
      $display("FAIL single_len: grant cycles %0d, required 5", glen);
    end
    low = 0;
    busy_cnt = 0;
    while (bus.grant[0] !== 1'b1 && low < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      low++;
      tick("single_gap");
    end
    n_cmp++;
    if (low != GAP + 1 || busy_cnt != GAP) begin
      n_bad++;
      $display("FAIL single_gap: low=%0d busy_after=%0d, required %0d and %0d", low, busy_cnt, GAP + 1, GAP);
    end
    n_cmp++;
    if (bus.timeout_err !== '0) begin
      n_bad++;
      $display("FAIL single_err: timeout_err=%b, required 0", bus.timeout_err);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int glen, waited;
    reset_dut();
    bus.req = '1;
    for (int s = 0; s < 5; s++) begin
      serve(order[s], 4, 0, "rr", glen, waited);
      n_cmp++;
      if (glen != 4 || (s > 0 && waited != GAP + 1)) begin
        n_bad++;
        $display("FAIL rr_step%0d: len=%0d gap=%0d, required 4 and %0d", s, glen, waited, GAP + 1);
      end
    end
    drain();
  endtask

  task automatic test_timeout();
    int glen, waited, regrants;
    reset_dut();
    bus.req[2] = 1'b1;
    serve(2, 0, 0, "tmo", glen, waited);
    n_cmp++;
    if (glen != FILL_MAX || bus.timeout_err[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_len: len=%0d err=%b, required %0d and err[2]=1", glen, bus.timeout_err, FILL_MAX);
    end
    regrants = 0;
    repeat (20) begin
      tick("tmo_hold");
      if (bus.valve_open === 1'b1) regrants++;
    end
    n_cmp++;
    if (regrants != 0) begin
      n_bad++;
      $display("FAIL tmo_no_regrant: valve open %0d cycles, required 0", regrants);
    end
    bus.req[2] = 1'b0;
    tick("tmo_clear");
    n_cmp++;
    if (bus.timeout_err[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_clear: err[2]=%b, required 0", bus.timeout_err[2]);
    end
    bus.req[2] = 1'b1;
    serve(2, 3, 0, "tmo_again", glen, waited);
    n_cmp++;
    if (glen != 3) begin
      n_bad++;
      $display("FAIL tmo_again_len: len=%0d, required 3", glen);
    end
    drain();
  endtask

  task automatic test_withdraw();
    int glen, waited;
    reset_dut();
    bus.req[1] = 1'b1;
    serve(1, 0, 10, "wd", glen, waited);
    n_cmp++;
    if (glen != 10 || bus.timeout_err[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_len: len=%0d err=%b, required 10 and err[1]=0", glen, bus.timeout_err);
    end
    bus.req = 4'b0101;
    serve(2, 2, 0, "wd_ptr", glen, waited);
    n_cmp++;
    if (waited != GAP + 1) begin
      n_bad++;
      $display("FAIL wd_ptr: requester 2 granted after %0d cycles, required %0d", waited, GAP + 1);
    end
    drain();
  endtask

  task automatic test_full_at_limit();
    int glen, waited;
    reset_dut();
    bus.req[3] = 1'b1;
    serve(3, FILL_MAX, 0, "limit", glen, waited);
    n_cmp++;
    if (glen != FILL_MAX || bus.timeout_err[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL limit: len=%0d err=%b, required %0d and err[3]=0", glen, bus.timeout_err, FILL_MAX);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int waited, glen;
    reset_dut();
    bus.req[1] = 1'b1;
    waited = 0;
    while (bus.grant[1] !== 1'b1 && waited < 50) begin
      tick("arst_wait");
      waited++;
    end
    glen = 1;
    while (glen < 50) begin
      tick("arst_fill");
      glen++;
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.grant !== '0 || bus.valve_open !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_close: grant=%b valve=%b busy=%b, required all 0", bus.grant, bus.valve_open, bus.busy);
    end
    model_reset();
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 4'b0011;
    tick("arst_first");
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL arst_first: grant=%b, required 0001", bus.grant);
    end
    drain();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 19) == 0) bus.req[j] = ~bus.req[j];
        bus.full[j] = ($urandom_range(0, 99) < 2);
      end
      tick("random");
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_full_at_limit();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
